// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C master byte transmitter.
package i2c_pkg;

    // Byte-level controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Wide enough to count 8 data bits plus the ACK bit.
    localparam int unsigned BitCntW = 4;

    // Phase at which SCL is released (start of the high half).
    function automatic int unsigned ratio_half(input int unsigned ratio);
        return ratio / 2;
    endfunction

    // Mid-low phase: SDA changes here.
    function automatic int unsigned ratio_qtr(input int unsigned ratio);
        return ratio / 4;
    endfunction

    // Mid-high phase: SDA is sampled here.
    function automatic int unsigned ratio_q3(input int unsigned ratio);
        return (3 * ratio) / 4;
    endfunction

endpackage

// File: rtl/i2c_scl_phase_gen.sv
// Bit-period phase counter: produces the SCL level and the drive/sample/end strobes.
module i2c_scl_phase_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER_RATIO = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic scl_o,
    output logic drive_strobe_o,
    output logic sample_strobe_o,
    output logic period_end_o
);

    localparam int unsigned PhaseW = $clog2(CLK_DIVIDER_RATIO);
    localparam logic [PhaseW-1:0] Half = PhaseW'(ratio_half(CLK_DIVIDER_RATIO));
    localparam logic [PhaseW-1:0] Qtr  = PhaseW'(ratio_qtr(CLK_DIVIDER_RATIO));
    localparam logic [PhaseW-1:0] Q3   = PhaseW'(ratio_q3(CLK_DIVIDER_RATIO));
    localparam logic [PhaseW-1:0] Last = PhaseW'(CLK_DIVIDER_RATIO - 1);

    logic [PhaseW-1:0] phase_q, phase_d;

    // Next phase: held at zero while stopped, wraps at the end of each bit period.
    always_comb begin
        phase_d = phase_q;
        if (!run_i) begin
            phase_d = '0;
        end else if (phase_q == Last) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PhaseW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign scl_o           = (phase_q >= Half);
    assign drive_strobe_o  = run_i && (phase_q == Qtr);
    assign sample_strobe_o = run_i && (phase_q == Q3);
    assign period_end_o    = run_i && (phase_q == Last);

endmodule

// File: rtl/i2c_master_write_byte.sv
// I2C master byte transmitter: shifts 8 bits MSB-first, then samples the slave ACK.
module i2c_master_write_byte
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER_RATIO = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [7:0] data_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       finish_o,
    output logic       error_o
);

    state_e               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [BitCntW-1:0]   bit_q, bit_d;
    logic                 sda_q, sda_d;
    logic                 scl_idle_q, scl_idle_d;
    logic                 error_q, error_d;
    logic                 finish_q, finish_d;
    logic                 samp_q, samp_d;
    logic                 arb_q, arb_d;

    logic run;
    logic scl_level;
    logic drive_strobe;
    logic sample_strobe;
    logic period_end;

    assign run = (state_q == DATA) || (state_q == ACK);

    i2c_scl_phase_gen #(
        .CLK_DIVIDER_RATIO(CLK_DIVIDER_RATIO)
    ) u_phase_gen (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .run_i          (run),
        .scl_o          (scl_level),
        .drive_strobe_o (drive_strobe),
        .sample_strobe_o(sample_strobe),
        .period_end_o   (period_end)
    );

    // Byte FSM, shift register and bus drive next-state logic.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        sda_d      = sda_q;
        scl_idle_d = scl_idle_q;
        error_d    = error_q;
        finish_d   = 1'b0;
        samp_d     = samp_q;
        arb_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The finish cycle itself is still busy from the caller's point of view.
                if (enable_i && !finish_q) begin
                    state_d = DATA;
                    shift_d = data_i;
                    error_d = 1'b0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (drive_strobe) begin
                    sda_d = shift_q[7];
                end
                if (sample_strobe) begin
                    samp_d = sda_i;
                    arb_d  = sda_q & ~sda_i;
                end
                if (arb_q) begin
                    // Lost arbitration: release both lines and give up the bus.
                    state_d    = DONE;
                    scl_idle_d = 1'b1;
                    sda_d      = 1'b1;
                    error_d    = 1'b1;
                end else if (period_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + BitCntW'(1);
                    if (bit_q == BitCntW'(7)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (drive_strobe) begin
                    sda_d = 1'b1;
                end
                if (sample_strobe) begin
                    samp_d = sda_i;
                end
                if (period_end) begin
                    // Keep SCL low afterwards so the master retains the bus.
                    bit_d      = bit_q + BitCntW'(1);
                    error_d    = samp_q;
                    scl_idle_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                finish_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset to the released-bus condition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            sda_q      <= 1'b1;
            scl_idle_q <= 1'b1;
            error_q    <= 1'b0;
            finish_q   <= 1'b0;
            samp_q     <= 1'b1;
            arb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            sda_q      <= sda_d;
            scl_idle_q <= scl_idle_d;
            error_q    <= error_d;
            finish_q   <= finish_d;
            samp_q     <= samp_d;
            arb_q      <= arb_d;
        end
    end

    assign scl_o    = run ? scl_level : scl_idle_q;
    assign sda_o    = sda_q;
    assign finish_o = finish_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_i2c_master_write_byte.sv
// Self-checking bench: open-drain bus with a behavioural slave receiver and reference model.
module tb_i2c_master_write_byte;

    localparam int unsigned R     = 8;
    localparam int unsigned Q3    = (3 * R) / 4;
    localparam int          NormN = 9 * R + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] data = 8'h00;
    logic       sda_i;
    logic       scl_o, sda_o, finish_o, error_o;

    int tests = 0;
    int fails = 0;

    // Slave-side controls
    logic slave_pull = 1'b0;
    logic force_low  = 1'b0;
    logic mon_clear  = 1'b0;
    logic ack_en     = 1'b1;
    int   force_idx  = -1;

    // Slave-side observations
    logic       scl_prev = 1'b1;
    int         rise_cnt = 0;
    logic [7:0] rx_byte  = 8'h00;
    logic       ack_seen = 1'b1;

    always #5 clk = ~clk;

    // Wired-AND bus
    assign sda_i = sda_o & ~slave_pull & ~force_low;

    i2c_master_write_byte #(
        .CLK_DIVIDER_RATIO(R)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .enable_i(enable),
        .data_i  (data),
        .sda_i   (sda_i),
        .scl_o   (scl_o),
        .sda_o   (sda_o),
        .finish_o(finish_o),
        .error_o (error_o)
    );

    // Slave receiver: captures SDA on SCL rise, ACKs in the 9th clock, optional forced low.
    always @(negedge clk) begin
        if (mon_clear) begin
            rise_cnt   = 0;
            rx_byte    = 8'h00;
            slave_pull = 1'b0;
            force_low  = 1'b0;
        end else if (!scl_prev && scl_o) begin
            if (rise_cnt < 8) begin
                rx_byte = {rx_byte[6:0], sda_i};
                if (rise_cnt == force_idx) force_low = 1'b1;
            end else if (rise_cnt == 8) begin
                ack_seen = sda_i;
            end
            rise_cnt++;
        end else if (scl_prev && !scl_o) begin
            force_low  = 1'b0;
            slave_pull = (rise_cnt == 8) ? ack_en : 1'b0;
        end
        scl_prev = scl_o;
    end

    task automatic start_xfer(input logic [7:0] d);
        @(posedge clk); #1;
        mon_clear = 1'b1;
        data      = d;
        enable    = 1'b1;
        @(posedge clk); #1;
        enable    = 1'b0;
        mon_clear = 1'b0;
    endtask

    task automatic wait_finish(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!finish_o && n < 300);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (scl_o !== 1'b1 || sda_o !== 1'b1 || finish_o !== 1'b0 || error_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: scl=%b sda=%b fin=%b err=%b expected 1 1 0 0",
                     scl_o, sda_o, finish_o, error_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (scl_o !== 1'b1 || sda_o !== 1'b1 || finish_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: scl=%b sda=%b fin=%b expected 1 1 0",
                     scl_o, sda_o, finish_o);
        end
    endtask

    // One full byte; the model says: all 8 bits on the wire, finish at 9*R+1, error = NACK.
    task automatic run_byte(input string name, input logic [7:0] d, input logic ack);
        int   n;
        logic err_early;
        logic exp_err;
        exp_err = ~ack;
        ack_en  = ack;
        start_xfer(d);
        err_early = error_o;
        wait_finish(n);
        tests++;
        if (n !== NormN) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, NormN);
        end
        tests++;
        if (rx_byte !== d) begin
            fails++;
            $display("FAIL %s_byte: got %02h expected %02h", name, rx_byte, d);
        end
        tests++;
        if (error_o !== exp_err || err_early !== 1'b0) begin
            fails++;
            $display("FAIL %s_error: got %b (at accept %b) expected %b (at accept 0)",
                     name, error_o, err_early, exp_err);
        end
        tests++;
        if (scl_o !== 1'b0 || sda_o !== 1'b1) begin
            fails++;
            $display("FAIL %s_hold: scl=%b sda=%b expected 0 1", name, scl_o, sda_o);
        end
        @(posedge clk); #1;
        tests++;
        if (finish_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_pulse: finish=%b expected 0", name, finish_o);
        end
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (error_o !== exp_err || scl_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_err_hold: err=%b scl=%b expected %b 0", name, error_o, scl_o, exp_err);
        end
    endtask

    // Slave forces SDA low in the high phase of bit k; abort happens only if the master sent a 1.
    task automatic test_arbitration(input string name, input logic [7:0] d, input int k);
        int         n;
        bit         abort;
        int         exp_n;
        logic [7:0] exp_rx;
        logic       scl_s, sda_s, err_s, fin_s;
        int         toggles;
        logic       last_scl;
        abort     = d[7-k];
        exp_n     = abort ? (k * R + Q3 + 3) : NormN;
        exp_rx    = abort ? (d >> (7 - k)) : d;
        ack_en    = 1'b1;
        force_idx = k;
        start_xfer(d);
        n = 0;
        scl_s = 1'bx; sda_s = 1'bx; err_s = 1'bx; fin_s = 1'bx;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == exp_n - 1) begin
                scl_s = scl_o; sda_s = sda_o; err_s = error_o; fin_s = finish_o;
            end
        end while (!finish_o && n < 300);
        force_idx = -1;
        tests++;
        if (n !== exp_n) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, exp_n);
        end
        tests++;
        if (rx_byte !== exp_rx || error_o !== abort) begin
            fails++;
            $display("FAIL %s_result: rx=%02h err=%b expected rx=%02h err=%b",
                     name, rx_byte, error_o, exp_rx, abort);
        end
        if (abort) begin
            tests++;
            if (scl_s !== 1'b1 || sda_s !== 1'b1 || err_s !== 1'b1 || fin_s !== 1'b0) begin
                fails++;
                $display("FAIL %s_release: scl=%b sda=%b err=%b fin=%b expected 1 1 1 0",
                         name, scl_s, sda_s, err_s, fin_s);
            end
            toggles  = 0;
            last_scl = scl_o;
            repeat (20) begin
                @(posedge clk); #1;
                if (scl_o !== last_scl) toggles++;
                last_scl = scl_o;
            end
            tests++;
            if (toggles != 0 || scl_o !== 1'b1 || sda_o !== 1'b1 || rise_cnt != k + 1) begin
                fails++;
                $display("FAIL %s_quiet: toggles=%0d scl=%b sda=%b rises=%0d expected 0 1 1 %0d",
                         name, toggles, scl_o, sda_o, rise_cnt, k + 1);
            end
        end else begin
            repeat (4) @(posedge clk);
        end
    endtask

    // Enable raised during the finish cycle must wait one more cycle before acceptance.
    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        int         n;
        int         pulses;
        bytes[0] = 8'h13; bytes[1] = 8'h57; bytes[2] = 8'h9B; bytes[3] = 8'hDF;
        pulses = 0;
        ack_en = 1'b1;
        start_xfer(bytes[0]);
        for (int i = 0; i < 4; i++) begin
            wait_finish(n);
            if (finish_o) pulses++;
            tests++;
            if (n !== NormN || rx_byte !== bytes[i] || error_o !== 1'b0) begin
                fails++;
                $display("FAIL b2b_%0d: n=%0d rx=%02h err=%b expected n=%0d rx=%02h err=0",
                         i, n, rx_byte, error_o, NormN, bytes[i]);
            end
            if (i < 3) begin
                mon_clear = 1'b1;
                data      = bytes[i+1];
                enable    = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                enable    = 1'b0;
                mon_clear = 1'b0;
            end
        end
        tests++;
        if (pulses != 4) begin
            fails++;
            $display("FAIL b2b_pulses: got %0d expected 4", pulses);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_ignore_enable();
        int n;
        ack_en = 1'b1;
        start_xfer(8'hC3);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 20) begin
                data   = 8'h00;
                enable = 1'b1;
            end else if (n == 21) begin
                enable = 1'b0;
            end
        end while (!finish_o && n < 300);
        tests++;
        if (n !== NormN || rx_byte !== 8'hC3 || error_o !== 1'b0) begin
            fails++;
            $display("FAIL ignore_enable: n=%0d rx=%02h err=%b expected n=%0d rx=c3 err=0",
                     n, rx_byte, error_o, NormN);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        ack_en = 1'b1;
        start_xfer(8'h6E);
        n = 0;
        while (n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (scl_o !== 1'b1 || sda_o !== 1'b1 || finish_o !== 1'b0 || error_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: scl=%b sda=%b fin=%b err=%b expected 1 1 0 0",
                     scl_o, sda_o, finish_o, error_o);
        end
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (finish_o) n++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (finish_o) n++;
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL reset_no_finish: got %0d pulses expected 0", n);
        end
        run_byte("after_reset", 8'(($urandom % 255) + 1), 1'b1);
    endtask

    initial begin
        test_reset();
        run_byte("ack_a5", 8'hA5, 1'b1);
        run_byte("nack_3c", 8'h3C, 1'b0);
        test_arbitration("arb_ff_b2", 8'hFF, 2);
        test_back_to_back();
        test_ignore_enable();
        test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            run_byte($sformatf("rand%0d", i), 8'($urandom), 1'($urandom % 2));
        end
        for (int i = 0; i < 6; i++) begin
            test_arbitration($sformatf("rand_arb%0d", i), 8'($urandom), int'($urandom % 8));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_master_write_byte.md
Name: i2c_master_write_byte

Overview:
- I2C master byte transmitter; the stage directly upstream, on the bus, of the slave byte receiver (i2c slave_read_byte).
- On an enable pulse it generates SCL and shifts 8 data bits out MSB-first on SDA.
- It then releases SDA for the 9th (ACK) clock and samples the slave's acknowledge.
- Invoked by the master controller FSM after START, with SCL already low.

Parameters:
- CLK_DIVIDER_RATIO, 8: system clocks per SCL period. Must be even and >= 8; the quarter points are RATIO/4 (integer division).

Ports:
- clock, input, 1: system clock, rising-edge.
- reset_n, input, 1: asynchronous active-low reset.
- enable, input, 1: start pulse. Sampled only in IDLE.
- data, input, 8: byte to send. Latched on the accepted enable.
- sda_in, input, 1: resolved bus SDA level. Assumed already synchronised by the pad wrapper.
- scl_out, output, 1: SCL drive. 0 = pull low, 1 = release.
- sda_out, output, 1: SDA drive. 0 = pull low, 1 = release.
- finish, output, 1: one-cycle pulse at the end of the byte or on abort.
- error, output, 1: level, valid from finish onward. 1 = NACK or arbitration lost.

Behaviour:
- Reset (async): state IDLE, scl_out=1, sda_out=1, finish=0, error=0, shift register 0, phase 0, bit count 0.
- States and transitions:
  - IDLE -> DATA on enable. On that edge: latch data, clear error, phase=0, bit=0.
  - DATA: 8 bit periods. After the bit-7 period -> ACK.
  - ACK: 1 bit period with sda_out=1. Then -> DONE.
  - DONE: assert finish for one cycle -> IDLE.
- Bit period = CLK_DIVIDER_RATIO cycles, phase counter p = 0..RATIO-1:
  - scl_out=0 for p < RATIO/2; scl_out=1 for p >= RATIO/2.
  - sda_out is updated at p == RATIO/4 (mid-low). DATA drives shift[7]; ACK drives 1.
  - sda_in is sampled at p == 3*RATIO/4 (mid-high).
  - At p == RATIO-1: shift left one, bit count +1, p wraps to 0.
- Arbitration loss:
  - Condition: in DATA, sda_out==1 and sampled sda_in==0.
  - Next edge: scl_out=1, sda_out=1, error=1, state -> DONE. finish asserts the following cycle.
- NACK: in ACK, sampled sda_in==1 -> error=1 at the end of the ACK period.
- Latency:
  - Normal: finish high exactly 9*RATIO+1 cycles after the edge that accepted enable (73 cycles at RATIO=8).
  - Arbitration abort: finish 2 cycles after the sample edge.
- Idle hold:
  - After a normal finish, scl_out holds 0 (master retains the bus). sda_out holds 1 (released after ACK).
  - After an abort, both hold 1.
  - After reset, both 1.
- error holds until the next accepted enable.
- enable while not IDLE is ignored: no relatch, no restart.
- enable in the same cycle as finish is ignored. It is accepted from the next cycle.
- Clock stretching is not supported. SCL is driven open-loop.
- Reset mid-transfer: all outputs return to reset values immediately. No finish pulse.

Decomposition:
- Package i2c_pkg:
  - state enum: IDLE, DATA, ACK, DONE.
  - localparam helpers HALF=RATIO/2, QTR=RATIO/4, Q3=3*RATIO/4.
  - bit-count width 4.
- One sub-module, i2c_scl_phase_gen:
  - Inputs: run, clock, reset_n.
  - Outputs: scl level, drive_strobe (p==QTR), sample_strobe (p==Q3), period_end (p==RATIO-1).
  - Counter resets to 0 when run=0.
- The byte FSM and shift register stay in i2c_master_write_byte.

Test Plan:
1. RATIO=8, data=8'hA5, slave model ACKs (sda_in=0 in ACK high phase).
   -> SDA sequence at SCL rising edges is 1,0,1,0,0,1,0,1. finish 73 cycles after enable, error=0, scl_out=0 afterwards.
2. data=8'h3C, slave releases SDA in ACK (NACK).
   -> 8 bits correct, finish at cycle 73, error=1 held until the next enable.
3. data=8'hFF, sda_in forced 0 during the high phase of bit 2.
   -> error=1, scl_out=sda_out=1 one cycle after the bit-2 sample edge, finish the following cycle, no further SCL toggles.
4. Loopback to the i2c slave_read_byte model, bytes 13,57,9B,DF back-to-back, each enabled the cycle after finish.
   -> slave reports each byte exactly, 4 finish pulses, no errors.
5. enable re-pulsed with data=8'h00 at cycle 20 of an 8'hC3 transfer.
   -> ignored. Transmitted byte stays C3 and finish timing is unchanged.
6. reset_n low at cycle 30 of a transfer.
   -> scl_out=1, sda_out=1, finish=0, error=0 asynchronously. A new enable after release sends a full correct byte.
